// File: rtl/rr_mux_pkg.sv
// Shared constants and types for the round-robin arbiter mux.
// The lock FSM state type is used only when RRMUX_LOCK_EN is defined.
package rr_mux_pkg;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;
endpackage

// File: rtl/rr_arbiter_mux_if.sv
// Handshake bundle between producers/consumer and rr_arbiter_mux.
// in_last exists only when RRMUX_LOCK_EN is defined.
interface rr_arbiter_mux_if
  import rr_mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                         mode;
  logic [CHANNELS*WIDTH-1:0]    in_data;
  logic [CHANNELS-1:0]          in_valid;
  logic [CHANNELS-1:0]          in_ready;
  logic [WIDTH-1:0]             out_data;
  logic [SEL_W-1:0]             out_sel;
  logic                         out_valid;
  logic                         out_ready;
`ifdef RRMUX_LOCK_EN
  logic [CHANNELS-1:0]          in_last;

  modport master (output mode, in_data, in_valid, in_last, out_ready,
                  input  in_ready, out_data, out_sel, out_valid);
  modport slave  (input  mode, in_data, in_valid, in_last, out_ready,
                  output in_ready, out_data, out_sel, out_valid);
`else
  modport master (output mode, in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_sel, out_valid);
  modport slave  (input  mode, in_data, in_valid, out_ready,
                  output in_ready, out_data, out_sel, out_valid);
`endif
endinterface

// File: rtl/rr_arbiter_mux_priority_pick.sv
// Rotating priority encoder: first request at or above i_start (mod N),
// or the lowest request when i_fixed is set.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_start,
  input  logic          i_fixed,
  output logic [N-1:0]  o_gnt,
  output logic [SW-1:0] o_idx,
  output logic          o_any
);
  int w_cand;

  // Walk from farthest to nearest so the nearest requester is written last.
  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    o_gnt  = '0;
    w_cand = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = k + (i_fixed ? 0 : int'(i_start));
      if (w_cand >= N) w_cand = w_cand - N;
      if (i_req[SW'(w_cand)]) begin
        o_any = 1'b1;
        o_idx = SW'(w_cand);
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end
endmodule

// File: rtl/rr_arbiter_mux.sv
// N-channel handshaked arbiter with a one-entry registered output stage.
// Define RRMUX_LOCK_EN to add in_last and packet locking.
module rr_arbiter_mux
  import rr_mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic          clk,
  input  logic          reset,
  rr_arbiter_mux_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS-1:0] w_req;
  logic [CHANNELS-1:0] w_gnt;
  logic [SEL_W-1:0]    w_idx;
  logic                w_any;
  logic                w_free;
  logic                w_xfer;
  logic                w_last;

  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_sel;
  logic                r_valid;
  logic [SEL_W-1:0]    r_ptr;

  assign w_free = !r_valid || bus.out_ready;

`ifdef RRMUX_LOCK_EN
  lock_state_e         r_lock, w_lock_nxt;
  logic [SEL_W-1:0]    r_lock_ch, w_lock_ch_nxt;

  // While a packet is open only its channel may be granted.
  assign w_req  = (r_lock == LOCK_HELD) ?
                  (bus.in_valid & (CHANNELS'(1) << r_lock_ch)) : bus.in_valid;
  assign w_last = bus.in_last[w_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock    <= LOCK_IDLE;
      r_lock_ch <= '0;
    end else begin
      r_lock    <= w_lock_nxt;
      r_lock_ch <= w_lock_ch_nxt;
    end
  end

  always_comb begin
    w_lock_nxt    = r_lock;
    w_lock_ch_nxt = r_lock_ch;
    case (r_lock)
      LOCK_IDLE: if (w_xfer && !w_last) begin
        w_lock_nxt    = LOCK_HELD;
        w_lock_ch_nxt = w_idx;
      end
      LOCK_HELD: if (w_xfer && w_last) w_lock_nxt = LOCK_IDLE;
      default:   w_lock_nxt = LOCK_IDLE;
    endcase
  end
`else
  assign w_req  = bus.in_valid;
  assign w_last = 1'b1;
`endif

  rr_priority_pick #(.N(CHANNELS), .SW(SEL_W)) u_pick (
    .i_req   (w_req),
    .i_start (r_ptr),
    .i_fixed (bus.mode == MODE_FIXED),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_xfer       = w_free && w_any;
  assign bus.in_ready = w_free ? w_gnt : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_data  <= bus.in_data[int'(w_idx)*WIDTH +: WIDTH];
      r_sel   <= w_idx;
      r_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Pointer moves past the winner only when its packet completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ptr <= '0;
    else if (w_xfer && bus.mode == MODE_RR && w_last)
      r_ptr <= (w_idx == SEL_W'(CHANNELS - 1)) ? '0 : w_idx + SEL_W'(1);
  end

  assign bus.out_data  = r_data;
  assign bus.out_sel   = r_sel;
  assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Directed and randomized checks of rr_arbiter_mux against a behavioural model.
module tb_rr_arbiter_mux;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  rr_arbiter_mux_if #(.WIDTH(W), .CHANNELS(N)) bus ();
  rr_arbiter_mux #(.WIDTH(W), .CHANNELS(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference model state
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;
  logic         m_locked;
  int           m_lock_ch;
  int           last_gnt;
  logic [N-1:0] obs_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
    m_locked = 0; m_lock_ch = 0; last_gnt = -1;
  endtask

  // Winner = eligible requester at smallest rotational distance from ptr
  // (or smallest index in fixed mode).
  function automatic int model_grant();
    int best = -1;
    int bestd = N;
    int d;
    for (int i = 0; i < N; i++) begin
      if (bus.in_valid[i] && (!m_locked || i == m_lock_ch)) begin
        d = bus.mode ? i : (i - m_ptr + N) % N;
        if (d < bestd) begin bestd = d; best = i; end
      end
    end
    return best;
  endfunction

  task automatic cycle();
    int g;
    logic free, lst;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    free = !m_valid || bus.out_ready;
    g = model_grant();
    exp_rdy = (free && g >= 0) ? N'(1 << g) : '0;
    obs_rdy = bus.in_ready;
    chk("in_ready", 32'(obs_rdy), 32'(exp_rdy));
    last_gnt = (free && g >= 0) ? g : -1;
    @(posedge clk);
    if (last_gnt >= 0) begin
      m_data  = bus.in_data[last_gnt*W +: W];
      m_sel   = last_gnt;
      m_valid = 1;
`ifdef RRMUX_LOCK_EN
      lst = bus.in_last[last_gnt];
`else
      lst = 1'b1;
`endif
      if (!m_locked && !lst) begin m_locked = 1; m_lock_ch = last_gnt; end
      else if (m_locked && lst) m_locked = 0;
      if (!bus.mode && lst) m_ptr = (last_gnt + 1) % N;
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_data",  32'(bus.out_data),  32'(m_data));
    chk("out_sel",   32'(bus.out_sel),   32'(m_sel));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = '0;
    #1;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int           exp_sel [5];
  logic [W-1:0] exp_dat [5];
  logic [W-1:0] hold_d;
  logic [1:0]   hold_s;

  initial begin
    reset = 1'b1;
    bus.mode = 1'b0;
    bus.in_data = '0;
    bus.in_valid = '0;
    bus.out_ready = 1'b0;
`ifdef RRMUX_LOCK_EN
    bus.in_last = '1;
`endif
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset state, idle
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data",  32'(bus.out_data),  32'd0);
    chk("rst_sel",   32'(bus.out_sel),   32'd0);
    chk("rst_ready", 32'(bus.in_ready),  32'd0);
    cycle();

    // Round robin over four always-valid channels
    exp_sel = '{0, 1, 2, 3, 0};
    exp_dat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    bus.mode = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 8'hA0 + 8'(i);
    bus.in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_sel",  32'(bus.out_sel),  32'(exp_sel[k]));
      chk("rr_data", 32'(bus.out_data), 32'(exp_dat[k]));
    end

    // Fixed priority: channel 3 starves behind channel 1
    bus.mode = 1'b1;
    bus.in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("fix_ready", 32'(obs_rdy),     32'h2);
      chk("fix_sel",   32'(bus.out_sel), 32'd1);
    end

    // Backpressure holds the output stage
    bus.out_ready = 1'b0;
    hold_d = bus.out_data;
    hold_s = bus.out_sel;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_ready", 32'(obs_rdy),       32'd0);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_data",  32'(bus.out_data),  32'(hold_d));
      chk("bp_sel",   32'(bus.out_sel),   32'(hold_s));
    end
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_release", 32'(obs_rdy), 32'h2);

    // Asynchronous reset with a word held; ptr (currently 1) restarts at 0
    bus.mode = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_data",  32'(bus.out_data),  32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    bus.in_valid = 4'b1111;
    cycle();
    chk("arst_first", 32'(bus.out_sel), 32'd0);

    // Randomized traffic against the model
    bus.in_valid = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (last_gnt == i) bus.in_valid[i] = 1'b0;
        if (!bus.in_valid[i] && $urandom_range(0, 2) != 0) begin
          bus.in_valid[i] = 1'b1;
          bus.in_data[i*W +: W] = W'($urandom);
`ifdef RRMUX_LOCK_EN
          bus.in_last[i] = 1'($urandom);
`endif
        end
      end
      bus.out_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
      cycle();
    end

`ifdef RRMUX_LOCK_EN
    // Channel 2 sends a 3-word packet while everyone requests
    do_reset();
    bus.mode = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_last = 4'b1111;
    bus.in_valid = 4'b0010;
    cycle();
    bus.in_valid = 4'b1111;
    bus.in_last = 4'b1011;
    bus.in_data[2*W +: W] = 8'hC0;
    cycle();
    chk("lock_w1", 32'(bus.out_sel), 32'd2);
    bus.mode = 1'b1;
    bus.in_data[2*W +: W] = 8'hC1;
    cycle();
    chk("lock_w2", 32'(bus.out_sel), 32'd2);
    bus.mode = 1'b0;
    bus.in_last = 4'b1111;
    bus.in_data[2*W +: W] = 8'hC2;
    cycle();
    chk("lock_w3", 32'(bus.out_sel), 32'd2);
    chk("lock_d3", 32'(bus.out_data), 32'hC2);
    cycle();
    chk("lock_next", 32'(bus.out_sel), 32'd3);
`else
    do_reset();
    cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
